// File: rtl/pawc_wb_pkg.sv
// rtl/pawc_wb_pkg.sv - shared types and helpers for the Wishbone window bridge
// Contents: bridge FSM state enum, MAX_WIN window limit, window-index width helper.
package pawc_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int MAX_WIN = 8;

    // Width of a window index; never below 1 so a single-window build still has a port.
    function automatic int win_idx_width(input int n);
        int m;
        m = (n > MAX_WIN) ? MAX_WIN : n;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/wb_window_bridge_if.sv
// rtl/wb_window_bridge_if.sv - bus bundle between interconnect, bridge and window targets
// Signals: classic slave side s_wb_* (from interconnect), pipelined master side m_wb_*
// (N_WIN per-window cyc/stb/ack/stall, shared we/adr/dat/sel, packed per-window read data).
// Modports: slave = the bridge's view; master = the surrounding SoC / environment view.
interface wb_window_bridge_if #(
    parameter int N_WIN = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) ();

    logic                  s_wb_cyc;
    logic                  s_wb_stb;
    logic                  s_wb_we;
    logic [AW-1:0]         s_wb_adr;
    logic [DW-1:0]         s_wb_dat_i;
    logic [DW/8-1:0]       s_wb_sel;
    logic [DW-1:0]         s_wb_dat_o;
    logic                  s_wb_ack;
    logic                  s_wb_err;

    logic [N_WIN-1:0]      m_wb_cyc;
    logic [N_WIN-1:0]      m_wb_stb;
    logic                  m_wb_we;
    logic [AW-1:0]         m_wb_adr;
    logic [DW-1:0]         m_wb_dat_o;
    logic [DW/8-1:0]       m_wb_sel;
    logic [N_WIN-1:0]      m_wb_ack;
    logic [N_WIN-1:0]      m_wb_stall;
    logic [N_WIN*DW-1:0]   m_wb_dat_i;

    modport slave (
        input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_i, s_wb_sel,
        output s_wb_dat_o, s_wb_ack, s_wb_err,
        output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_dat_o, m_wb_sel,
        input  m_wb_ack, m_wb_stall, m_wb_dat_i
    );

    modport master (
        output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_dat_i, s_wb_sel,
        input  s_wb_dat_o, s_wb_ack, s_wb_err,
        input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_dat_o, m_wb_sel,
        output m_wb_ack, m_wb_stall, m_wb_dat_i
    );

endinterface

// File: rtl/wb_win_decode.sv
// rtl/wb_win_decode.sv - combinational address-window decoder with rebase
// Ports: adr (in, AW) byte address; hit (out) some window matched;
// index (out, IW) matching window, lowest index on overlap; rebased (out, AW) adr - base.
module wb_win_decode
    import pawc_wb_pkg::*;
#(
    parameter int                  N_WIN    = 2,
    parameter int                  AW       = 32,
    parameter int                  IW       = 1,
    parameter logic [N_WIN*AW-1:0] WIN_BASE = {32'h0001_0000, 32'h0000_1000},
    parameter logic [N_WIN*AW-1:0] WIN_SIZE = {32'h0001_0000, 32'h0000_1000}
) (
    input  logic [AW-1:0] adr,
    output logic          hit,
    output logic [IW-1:0] index,
    output logic [AW-1:0] rebased
);

    logic [AW-1:0] base;
    logic [AW-1:0] size;

    // Scan from the top index down so the lowest matching window is the last writer.
    always_comb begin
        hit     = 1'b0;
        index   = '0;
        rebased = '0;
        base    = '0;
        size    = '0;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            base = WIN_BASE[i*AW +: AW];
            size = WIN_SIZE[i*AW +: AW];
            if ((adr & ~(size - AW'(1))) == base) begin
                hit     = 1'b1;
                index   = IW'(i);
                rebased = adr - base;
            end
        end
    end

endmodule

// File: rtl/wb_window_bridge.sv
// rtl/wb_window_bridge.sv - classic Wishbone slave to N_WIN pipelined masters, windowed
// Ports: wb_clk (in) clock; wb_rst (in) async active-high reset;
// bus (wb_window_bridge_if.slave) slave request/response and per-window master bus.
// Optional macro WB_BRIDGE_TIMEOUT_EN adds the TIMEOUT_CYC bus watchdog.
module wb_window_bridge
    import pawc_wb_pkg::*;
#(
    parameter int                  N_WIN    = 2,
    parameter int                  AW       = 32,
    parameter int                  DW       = 32,
    parameter logic [N_WIN*AW-1:0] WIN_BASE = {32'h0001_0000, 32'h0000_1000},
    parameter logic [N_WIN*AW-1:0] WIN_SIZE = {32'h0001_0000, 32'h0000_1000}
`ifdef WB_BRIDGE_TIMEOUT_EN
    ,
    parameter int                  TIMEOUT_CYC = 255
`endif
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    wb_window_bridge_if.slave     bus
);

    localparam int IW = win_idx_width(N_WIN);

    state_t            state;
    logic [IW-1:0]     sel_idx;
    logic [N_WIN-1:0]  m_cyc_q;
    logic [N_WIN-1:0]  m_stb_q;
    logic              m_we_q;
    logic [AW-1:0]     m_adr_q;
    logic [DW-1:0]     m_dat_q;
    logic [DW/8-1:0]   m_sel_q;
    logic [DW-1:0]     s_dat_q;
    logic              s_ack_q;
    logic              s_err_q;

    logic              dec_hit;
    logic [IW-1:0]     dec_index;
    logic [AW-1:0]     dec_adr;

    logic [N_WIN-1:0]  sel_oh;
    logic              sel_ack;
    logic              sel_stall;
    logic [DW-1:0]     sel_rdata;
    logic              accepted;
    logic              tmo_hit;

    function automatic logic [N_WIN-1:0] onehot(input logic [IW-1:0] idx);
        return N_WIN'(1) << idx;
    endfunction

    wb_win_decode #(
        .N_WIN    (N_WIN),
        .AW       (AW),
        .IW       (IW),
        .WIN_BASE (WIN_BASE),
        .WIN_SIZE (WIN_SIZE)
    ) u_decode (
        .adr     (bus.s_wb_adr),
        .hit     (dec_hit),
        .index   (dec_index),
        .rebased (dec_adr)
    );

    // Selected-window views of the per-window inputs; masking avoids out-of-range indexing.
    always_comb begin
        sel_oh    = onehot(sel_idx);
        sel_ack   = |(bus.m_wb_ack & sel_oh);
        sel_stall = |(bus.m_wb_stall & sel_oh);
        sel_rdata = '0;
        for (int i = 0; i < N_WIN; i++) begin
            if (sel_oh[i]) begin
                sel_rdata = bus.m_wb_dat_i[i*DW +: DW];
            end
        end
    end

    // In REQ an ack only counts on the cycle the strobe is actually taken (stall low).
    assign accepted = (state == ST_REQ) ? !sel_stall : 1'b1;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state   <= ST_IDLE;
            sel_idx <= '0;
            m_cyc_q <= '0;
            m_stb_q <= '0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            s_dat_q <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    s_ack_q <= 1'b0;
                    s_err_q <= 1'b0;
                    s_dat_q <= '0;
                    if (bus.s_wb_cyc && bus.s_wb_stb) begin
                        sel_idx <= dec_index;
                        m_we_q  <= bus.s_wb_we;
                        m_adr_q <= dec_adr;
                        m_dat_q <= bus.s_wb_dat_i;
                        m_sel_q <= bus.s_wb_sel;
                        if (dec_hit) begin
                            m_cyc_q <= onehot(dec_index);
                            m_stb_q <= onehot(dec_index);
                            state   <= ST_REQ;
`ifdef WB_BRIDGE_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end else begin
                            s_err_q <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end

                ST_REQ, ST_WAIT: begin
`ifdef WB_BRIDGE_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + CW'(1);
`endif
                    if (!bus.s_wb_cyc) begin
                        // Upstream gave up: release the target silently.
                        m_cyc_q <= '0;
                        m_stb_q <= '0;
                        state   <= ST_IDLE;
                    end else if (accepted && sel_ack) begin
                        m_cyc_q <= '0;
                        m_stb_q <= '0;
                        s_ack_q <= 1'b1;
                        s_dat_q <= m_we_q ? '0 : sel_rdata;
                        state   <= ST_RESP;
                    end else if (tmo_hit) begin
                        m_cyc_q <= '0;
                        m_stb_q <= '0;
                        s_err_q <= 1'b1;
                        state   <= ST_RESP;
                    end else if (state == ST_REQ && !sel_stall) begin
                        m_stb_q <= '0;
                        state   <= ST_WAIT;
                    end
                end

                ST_RESP: begin
                    s_ack_q <= 1'b0;
                    s_err_q <= 1'b0;
                    s_dat_q <= '0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_wb_dat_o = s_dat_q;
    assign bus.s_wb_ack   = s_ack_q;
    assign bus.s_wb_err   = s_err_q;
    assign bus.m_wb_cyc   = m_cyc_q;
    assign bus.m_wb_stb   = m_stb_q;
    assign bus.m_wb_we    = m_we_q;
    assign bus.m_wb_adr   = m_adr_q;
    assign bus.m_wb_dat_o = m_dat_q;
    assign bus.m_wb_sel   = m_sel_q;

endmodule

// File: tb/tb_wb_window_bridge.sv
// tb/tb_wb_window_bridge.sv - self-checking bench for wb_window_bridge
module tb_wb_window_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_window_bridge_if #(.N_WIN(2), .AW(32), .DW(32)) bus ();

    wb_window_bridge #(
        .N_WIN    (2),
        .AW       (32),
        .DW       (32),
        .WIN_BASE ({32'h0001_0000, 32'h0000_1000}),
        .WIN_SIZE ({32'h0001_0000, 32'h0000_1000})
`ifdef WB_BRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .wb_clk (clk),
        .wb_rst (rst),
        .bus    (bus)
    );

    localparam logic [31:0] REF_BASE [2] = '{32'h0000_1000, 32'h0001_0000};
    localparam logic [31:0] REF_SIZE [2] = '{32'h0000_1000, 32'h0001_0000};

    int checks = 0;
    int errors = 0;

    int          h_ack_n, h_err_n, h_ack_at, h_err_at;
    int          h_stb_cnt [2];
    logic [1:0]  h_cyc_or;
    logic [31:0] h_ack_dat, h_err_dat;
    logic [1:0]  h_cyc [0:63];
    logic [31:0] h_adr [0:63];
    logic        h_we1;
    logic [31:0] h_wdat1;
    logic [3:0]  h_sel1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: range test against the window table.
    task automatic ref_decode(input logic [31:0] a, output bit hit, output int idx, output logic [31:0] reb);
        longint unsigned av, b, s;
        hit = 1'b0;
        idx = 0;
        reb = '0;
        av  = 64'(a);
        for (int i = 0; i < 2; i++) begin
            b = 64'(REF_BASE[i]);
            s = 64'(REF_SIZE[i]);
            if (!hit && av >= b && av < b + s) begin
                hit = 1'b1;
                idx = i;
                reb = a - REF_BASE[i];
            end
        end
    endtask

    // One slave transaction; target window 'win' stalls stall_n cycles, acks ack_dly
    // cycles after taking the strobe (-1 = never). History is sampled at each negedge.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] sel, input int win, input int stall_n,
                           input int ack_dly, input logic [31:0] rdata, input bit early_ack,
                           input int abort_n, input int max_cyc);
        int accept_edge;
        int stall_left;
        accept_edge = -1;
        stall_left  = stall_n;
        h_ack_n = 0; h_err_n = 0; h_ack_at = -1; h_err_at = -1;
        h_stb_cnt[0] = 0; h_stb_cnt[1] = 0;
        h_cyc_or = '0; h_ack_dat = '0; h_err_dat = '0;
        for (int k = 0; k < 64; k++) begin
            h_cyc[k] = '0;
            h_adr[k] = '0;
        end
        @(negedge clk);
        bus.s_wb_cyc   = 1'b1;
        bus.s_wb_stb   = 1'b1;
        bus.s_wb_we    = we;
        bus.s_wb_adr   = addr;
        bus.s_wb_dat_i = wdata;
        bus.s_wb_sel   = sel;
        bus.m_wb_stall = '0;
        bus.m_wb_ack   = '0;
        bus.m_wb_dat_i = {~rdata, ~rdata};
        bus.m_wb_dat_i[win*32 +: 32] = rdata;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            h_cyc[n] = bus.m_wb_cyc;
            h_adr[n] = bus.m_wb_adr;
            h_cyc_or = h_cyc_or | bus.m_wb_cyc;
            if (n == 1) begin
                h_we1   = bus.m_wb_we;
                h_wdat1 = bus.m_wb_dat_o;
                h_sel1  = bus.m_wb_sel;
            end
            for (int w = 0; w < 2; w++) if (bus.m_wb_stb[w]) h_stb_cnt[w]++;
            if (bus.s_wb_ack) begin
                h_ack_n++;
                if (h_ack_at < 0) begin
                    h_ack_at  = n;
                    h_ack_dat = bus.s_wb_dat_o;
                end
            end
            if (bus.s_wb_err) begin
                h_err_n++;
                if (h_err_at < 0) begin
                    h_err_at  = n;
                    h_err_dat = bus.s_wb_dat_o;
                end
            end
            if (bus.s_wb_ack || bus.s_wb_err || n == abort_n) begin
                bus.s_wb_cyc = 1'b0;
                bus.s_wb_stb = 1'b0;
            end
            bus.m_wb_stall = '0;
            bus.m_wb_ack   = '0;
            if (bus.m_wb_stb[win] && stall_left > 0) begin
                stall_left--;
                bus.m_wb_stall[win] = 1'b1;
            end else if (bus.m_wb_stb[win] && accept_edge < 0) begin
                accept_edge = n;
            end
            if (ack_dly >= 0 && accept_edge >= 0 && n == accept_edge + ack_dly) bus.m_wb_ack[win] = 1'b1;
            if (early_ack && n == 1) bus.m_wb_ack[win] = 1'b1;
        end
        bus.m_wb_stall = '0;
        bus.m_wb_ack   = '0;
    endtask

    initial begin
        bit          hit;
        int          idx, stall_n, dly, kind;
        logic [31:0] reb, addr, wdat, rdat;
        logic        we;

        bus.s_wb_cyc = 1'b0; bus.s_wb_stb = 1'b0; bus.s_wb_we = 1'b0;
        bus.s_wb_adr = '0; bus.s_wb_dat_i = '0; bus.s_wb_sel = '0;
        bus.m_wb_ack = '0; bus.m_wb_stall = '0; bus.m_wb_dat_i = '0;

        #1;
        chk("rst_m_cyc", bus.m_wb_cyc, 2'b00);
        chk("rst_m_stb", bus.m_wb_stb, 2'b00);
        chk("rst_s_ack", bus.s_wb_ack, 1'b0);
        chk("rst_s_err", bus.s_wb_err, 1'b0);
        chk("rst_s_dat", bus.s_wb_dat_o, 32'h0);
        #20 rst = 1'b0;

        // Read in window 0, no stall, ack one cycle after the strobe is taken.
        run_txn(32'h0000_1010, 1'b0, 32'h0, 4'hF, 0, 0, 1, 32'hDEAD_BEEF, 1'b0, -1, 6);
        chk("rd_adr", h_adr[1], 32'h10);
        chk("rd_cyc", h_cyc[1], 2'b01);
        chk("rd_ack_at", h_ack_at, 3);
        chk("rd_ack_n", h_ack_n, 1);
        chk("rd_dat", h_ack_dat, 32'hDEAD_BEEF);

        // Write in window 1 with 4 stall cycles and an ack during stall that must be ignored.
        run_txn(32'h0001_0004, 1'b1, 32'h1234_5678, 4'hA, 1, 4, 1, 32'hCAFE_F00D, 1'b1, -1, 12);
        chk("wr_stb1_cycles", h_stb_cnt[1], 5);
        chk("wr_adr", h_adr[1], 32'h4);
        chk("wr_we", h_we1, 1'b1);
        chk("wr_dat", h_wdat1, 32'h1234_5678);
        chk("wr_sel", h_sel1, 4'hA);
        chk("wr_ack_n", h_ack_n, 1);
        chk("wr_ack_at", h_ack_at, 7);
        chk("wr_rdat_zero", h_ack_dat, 32'h0);
        chk("wr_cyc0_idle", h_cyc_or[0], 1'b0);

        // Decode miss.
        run_txn(32'h0000_0800, 1'b0, 32'h0, 4'hF, 0, 0, 1, 32'h1111_2222, 1'b0, -1, 5);
        chk("miss_cyc", h_cyc_or, 2'b00);
        chk("miss_err_n", h_err_n, 1);
        chk("miss_err_at", h_err_at, 1);
        chk("miss_ack_n", h_ack_n, 0);
        chk("miss_dat", h_err_dat, 32'h0);

        // Top-of-space address: no window covers it, no wrap into window 0.
        run_txn(32'hFFFF_FFFF, 1'b0, 32'h0, 4'hF, 0, 0, 1, 32'h3333_4444, 1'b0, -1, 5);
        chk("top_err_n", h_err_n, 1);
        chk("top_cyc", h_cyc_or, 2'b00);

`ifdef WB_BRIDGE_TIMEOUT_EN
        // Target never acks: watchdog fires 16 cycles after REQ is entered.
        run_txn(32'h0000_1100, 1'b0, 32'h0, 4'hF, 0, 0, -1, 32'h0, 1'b0, -1, 22);
        chk("tmo_cyc_before", h_cyc[16], 2'b01);
        chk("tmo_cyc_after", h_cyc[17], 2'b00);
        chk("tmo_err_at", h_err_at, 17);
        chk("tmo_err_n", h_err_n, 1);
        chk("tmo_ack_n", h_ack_n, 0);
`else
        // Target never acks: bridge holds the cycle until upstream aborts.
        run_txn(32'h0000_1100, 1'b0, 32'h0, 4'hF, 0, 0, -1, 32'h0, 1'b0, 38, 42);
        chk("hold_cyc", h_cyc[37], 2'b01);
        chk("hold_cyc_abort", h_cyc[39], 2'b00);
        chk("hold_err_n", h_err_n, 0);
        chk("hold_ack_n", h_ack_n, 0);
`endif

        // Abort while in WAIT, then a late ack arrives.
        run_txn(32'h0000_1200, 1'b0, 32'h0, 4'hF, 0, 0, 4, 32'h5555_6666, 1'b0, 3, 8);
        chk("abort_cyc_before", h_cyc[3], 2'b01);
        chk("abort_cyc_after", h_cyc[4], 2'b00);
        chk("abort_ack_n", h_ack_n, 0);
        chk("abort_err_n", h_err_n, 0);

        // Reset asserted while waiting for the target's ack.
        @(negedge clk);
        bus.s_wb_cyc = 1'b1; bus.s_wb_stb = 1'b1; bus.s_wb_we = 1'b1;
        bus.s_wb_adr = 32'h0000_1004; bus.s_wb_dat_i = 32'hA5A5_A5A5; bus.s_wb_sel = 4'hF;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("prerst_cyc", bus.m_wb_cyc, 2'b01);
        chk("prerst_stb", bus.m_wb_stb, 2'b00);
        #2 rst = 1'b1;
        #1;
        chk("arst_cyc", bus.m_wb_cyc, 2'b00);
        chk("arst_adr", bus.m_wb_adr, 32'h0);
        chk("arst_dat", bus.m_wb_dat_o, 32'h0);
        chk("arst_we", bus.m_wb_we, 1'b0);
        chk("arst_sel", bus.m_wb_sel, 4'h0);
        chk("arst_ack", bus.s_wb_ack, 1'b0);
        @(negedge clk);
        bus.s_wb_cyc = 1'b0; bus.s_wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_txn(32'h0000_1FFC, 1'b0, 32'h0, 4'hF, 0, 0, 1, 32'h0BAD_CAFE, 1'b0, -1, 6);
        chk("post_rst_ack_at", h_ack_at, 3);
        chk("post_rst_dat", h_ack_dat, 32'h0BAD_CAFE);
        chk("post_rst_adr", h_adr[1], 32'hFFC);

        // Randomized transactions against the reference model.
        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: addr = 32'h0000_1000 + ($urandom & 32'h0000_0FFF);
                1: addr = 32'h0001_0000 + ($urandom & 32'h0000_FFFF);
                2: addr = $urandom & 32'h0000_0FFF;
                default: addr = $urandom;
            endcase
            we      = 1'($urandom_range(0, 1));
            wdat    = $urandom;
            rdat    = $urandom;
            stall_n = $urandom_range(0, 3);
            dly     = $urandom_range(0, 3);
            ref_decode(addr, hit, idx, reb);
            run_txn(addr, we, wdat, 4'hF, idx, stall_n, dly, rdat, 1'b0, -1, stall_n + dly + 5);
            if (hit) begin
                chk("rnd_ack_n", h_ack_n, 1);
                chk("rnd_err_n", h_err_n, 0);
                chk("rnd_ack_at", h_ack_at, stall_n + 2 + dly);
                chk("rnd_adr", h_adr[1], reb);
                chk("rnd_cyc", h_cyc[1], 2'(1) << idx);
                chk("rnd_stb_cycles", h_stb_cnt[idx], stall_n + 1);
                chk("rnd_dat", h_ack_dat, we ? 32'h0 : rdat);
                chk("rnd_wdat", h_wdat1, wdat);
            end else begin
                chk("rnd_miss_err_n", h_err_n, 1);
                chk("rnd_miss_ack_n", h_ack_n, 0);
                chk("rnd_miss_err_at", h_err_at, 1);
                chk("rnd_miss_cyc", h_cyc_or, 2'b00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
